// File: rtl/smemw_pkg.sv
// Shared definitions for the streaming memory writer: FSM state encoding,
// AXI response/burst codes and the AWCACHE encodings used for the AW channel.
package smemw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } smemw_state_t;

    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // Write-back read/write-allocate versus plain normal non-cacheable bufferable.
    localparam logic [3:0] AWCACHE_ALLOCATE = 4'b1111;
    localparam logic [3:0] AWCACHE_NORMAL   = 4'b0011;

    // Selects the AWCACHE attribute for a transfer from its cache-update request.
    function automatic logic [3:0] awcache_encode(input logic force_update);
        logic [3:0] enc;
        if (force_update) begin
            enc = AWCACHE_ALLOCATE;
        end else begin
            enc = AWCACHE_NORMAL;
        end
        return enc;
    endfunction

    // Any response other than OKAY marks the transfer as failed.
    function automatic logic resp_is_error(input logic [1:0] resp);
        return (resp != AXI_RESP_OKAY);
    endfunction

endpackage

// File: rtl/smemw_pattern.sv
// Internal test-pattern source: a 32-bit counter that is cleared at transfer
// start, advances once per accepted beat, and is replicated across the bus.
module smemw_pattern
    import smemw_pkg::*;
#(
    parameter int DW = 512
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clear,
    input  logic          advance,
    output logic [DW-1:0] data
);

    localparam int LANES = DW / 32;

    logic [31:0] count_r;

    // Pattern counter: clear has priority so a new transfer always starts at zero.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_r <= 32'd0;
        end else if (clear) begin
            count_r <= 32'd0;
        end else if (advance) begin
            count_r <= count_r + 32'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // Replicate the counter into every 32-bit lane of the data bus.
    always_comb begin
        data = {DW{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            data[i*32 +: 32] = count_r;
        end
    end

endmodule

// File: rtl/smemw_writer.sv
// Streaming memory writer: issues burst_count back-to-back AXI INCR bursts of
// BURST_BEATS beats each, one burst outstanding at a time, sourcing data either
// from the HSI stream (zero-latency passthrough) or from an internal counter.
module smemw_writer
    import smemw_pkg::*;
#(
    parameter int DW          = 512,
    parameter int BURST_BEATS = 64
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          select_hsi,
    input  logic          force_cache_update,
    input  logic [63:0]   base_addr,
    input  logic [31:0]   burst_count,
    input  logic [DW-1:0] hsi_tdata,
    input  logic          hsi_tvalid,
    output logic          hsi_tready,
    output logic [63:0]   awaddr,
    output logic [7:0]    awlen,
    output logic [3:0]    awcache,
    output logic          awvalid,
    input  logic          awready,
    output logic [DW-1:0] wdata,
    output logic          wlast,
    output logic          wvalid,
    input  logic          wready,
    input  logic [1:0]    bresp,
    input  logic          bvalid,
    output logic          bready,
    output logic          busy,
    output logic          done,
    output logic          error
);

    localparam int               BEAT_W      = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_BEATS - 1);
    localparam logic [63:0]      BURST_BYTES = 64'(BURST_BEATS * (DW / 8));

    smemw_state_t      state_r;
    logic              select_hsi_r;
    logic [63:0]       awaddr_r;
    logic [3:0]        awcache_r;
    logic              awvalid_r;
    logic [31:0]       remaining_r;
    logic [BEAT_W-1:0] beat_r;
    logic              bready_r;
    logic              busy_r;
    logic              done_r;
    logic              error_r;

    logic              wvalid_s;
    logic              wlast_s;
    logic              w_fire_s;
    logic              pattern_clear_s;
    logic              pattern_advance_s;
    logic [DW-1:0]     pattern_data_s;

    smemw_pattern #(
        .DW (DW)
    ) u_pattern (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (pattern_clear_s),
        .advance (pattern_advance_s),
        .data    (pattern_data_s)
    );

    // W-channel muxing: HSI mode is a pure wire-through, pattern mode always offers a beat.
    always_comb begin
        wvalid_s   = 1'b0;
        hsi_tready = 1'b0;
        wdata      = pattern_data_s;
        if (state_r == ST_DATA) begin
            if (select_hsi_r) begin
                wvalid_s   = hsi_tvalid;
                hsi_tready = wready;
                wdata      = hsi_tdata;
            end else begin
                wvalid_s   = 1'b1;
                hsi_tready = 1'b0;
                wdata      = pattern_data_s;
            end
        end else begin
            wvalid_s   = 1'b0;
            hsi_tready = 1'b0;
            wdata      = pattern_data_s;
        end
    end

    // Beat bookkeeping derived from registered state; stalls leave these untouched.
    always_comb begin
        wlast_s           = (state_r == ST_DATA) && (beat_r == LAST_BEAT);
        w_fire_s          = wvalid_s && wready;
        pattern_clear_s   = (state_r == ST_IDLE) && start;
        pattern_advance_s = w_fire_s && !select_hsi_r;
    end

    // Transfer sequencer: latches the request, walks each burst through ADDR/DATA/RESP.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            select_hsi_r <= 1'b0;
            awaddr_r     <= 64'd0;
            awcache_r    <= AWCACHE_NORMAL;
            awvalid_r    <= 1'b0;
            remaining_r  <= 32'd0;
            beat_r       <= {BEAT_W{1'b0}};
            bready_r     <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        select_hsi_r <= select_hsi;
                        awcache_r    <= awcache_encode(force_cache_update);
                        awaddr_r     <= base_addr;
                        remaining_r  <= burst_count;
                        beat_r       <= {BEAT_W{1'b0}};
                        error_r      <= 1'b0;
                        if (burst_count == 32'd0) begin
                            done_r <= 1'b1;
                        end else begin
                            state_r   <= ST_ADDR;
                            awvalid_r <= 1'b1;
                            busy_r    <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (awready) begin
                        awvalid_r <= 1'b0;
                        state_r   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_fire_s) begin
                        if (wlast_s) begin
                            beat_r   <= {BEAT_W{1'b0}};
                            bready_r <= 1'b1;
                            state_r  <= ST_RESP;
                        end else begin
                            beat_r <= beat_r + BEAT_W'(1);
                        end
                    end
                end
                ST_RESP: begin
                    if (bvalid) begin
                        bready_r    <= 1'b0;
                        awaddr_r    <= awaddr_r + BURST_BYTES;
                        remaining_r <= remaining_r - 32'd1;
                        if (resp_is_error(bresp)) begin
                            error_r <= 1'b1;
                        end
                        if (remaining_r == 32'd1) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r   <= ST_ADDR;
                            awvalid_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    awvalid_r <= 1'b0;
                    bready_r  <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign awaddr  = awaddr_r;
    assign awlen   = 8'(BURST_BEATS - 1);
    assign awcache = awcache_r;
    assign awvalid = awvalid_r;
    assign wvalid  = wvalid_s;
    assign wlast   = wlast_s;
    assign bready  = bready_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign error   = error_r;

endmodule

// File: doc/smemw_writer.md
SMEMW_WRITER -- requirements
Module: smemw_writer

Interface
REQ-001 Clock and reset SHALL be: reset resetn, synchronous, active-low; clock clk.
REQ-002 DW, 512, AXI write-data and HSI stream width in bits (multiple of 32).
REQ-003 BURST_BEATS, 64, beats per AXI burst; BURST_BEATS*DW/8 SHALL divide 4096.
REQ-004 clk  in  1  clock.
REQ-005 resetn  in  1  sync active-low reset.
REQ-006 start  in  1  one-cycle pulse from control block; begins a transfer.
REQ-007 select_hsi  in  1  1 = data from HSI stream, 0 = internal counter pattern.
REQ-008 force_cache_update  in  1  1 = cacheable/allocating writes.
REQ-009 base_addr  in  64  first write address, burst-size aligned.
REQ-010 burst_count  in  32  number of bursts to write.
REQ-011 hsi_tdata  in  DW  HSI stream data.
REQ-012 hsi_tvalid  in  1  HSI stream valid.
REQ-013 hsi_tready  out  1  HSI stream ready.
REQ-014 awaddr  out  64  burst address.
REQ-015 awlen  out  8  BURST_BEATS-1.
REQ-016 awcache  out  4  4'b1111 if latched force_cache_update, else 4'b0011.
REQ-017 awvalid  out  1  / awready  in  1  AW handshake.
REQ-018 wdata  out  DW  write data.
REQ-019 wlast  out  1  high on final beat of each burst.
REQ-020 wvalid  out  1  / wready  in  1  W handshake.
REQ-021 bresp  in  2  write response code.
REQ-022 bvalid  in  1  / bready  out  1  B handshake.
REQ-023 busy  out  1  high whenever state is not IDLE.
REQ-024 done  out  1  one-cycle pulse at transfer completion.
REQ-025 error  out  1  sticky: some bresp was non-OKAY in the current or last transfer.
REQ-026 awsize, awburst and wstrb SHALL NOT be ported; the AXI wrapper ties them to full-width, INCR and all-ones.

Function
REQ-027 States SHALL be IDLE, ADDR, DATA and RESP; only one burst is outstanding at any time.
REQ-028 IDLE on start: latch select_hsi, force_cache_update, base_addr and burst_count; clear error; zero the pattern counter; go to ADDR. If burst_count==0, pulse done on the next cycle and stay IDLE.
REQ-029 start outside IDLE SHALL be ignored, as SHALL changes to select_hsi and force_cache_update during a transfer.
REQ-030 ADDR: hold awvalid with a stable awaddr/awcache until awready; on the handshake go to DATA in the next cycle.
REQ-031 DATA, HSI mode: wvalid=hsi_tvalid, hsi_tready=wready, wdata=hsi_tdata, all combinational passthrough with zero added latency.
REQ-032 DATA, pattern mode: wvalid=1, wdata = the 32-bit counter replicated DW/32 times; the counter increments per accepted beat and continues across bursts.
REQ-033 hsi_tready SHALL be 0 outside DATA, and 0 in pattern mode.
REQ-034 The beat counter SHALL assert wlast on beat BURST_BEATS-1; the last-beat handshake moves to RESP.
REQ-035 RESP: bready=1. On bvalid, set error if bresp!=0, add BURST_BEATS*DW/8 to the address (64-bit wrap), and decrement the remaining bursts. Go to ADDR if bursts remain; otherwise go to IDLE and pulse done in the same cycle.
REQ-036 A wready or hsi_tvalid stall SHALL hold wdata/wlast stable and SHALL NOT advance any counter.

Reset
REQ-037 Reset SHALL force state IDLE and drive awvalid, wvalid, bready, hsi_tready, busy, done and error to 0; resetting mid-burst abandons the burst without completing it.

Structure
REQ-038 A shared package smemw_pkg SHALL hold the state enum, the AXI OKAY/INCR codes and the AWCACHE encodings.
REQ-039 The pattern generator SHALL be a sub-module, smemw_pattern (counter, clear, advance, replicated output).

Verification
REQ-040 Pattern mode, base 0x1000, burst_count 2, DW=512, BURST_BEATS=64: two bursts at 0x1000 and 0x2000; word values 0..127; one done pulse.
REQ-041 HSI mode with random tvalid/wready gaps: wdata matches hsi_tdata in order; wlast occurs every 64 beats; no beats lost.
REQ-042 burst_count 0 -> no awvalid; done pulses the cycle after start; busy stays 0.
REQ-043 bresp=2 on burst 1 of 3 -> all 3 bursts complete; error=1 after done and cleared by the next start.
REQ-044 force_cache_update=1 -> awcache=4'b1111; a start pulse mid-transfer has no effect.
REQ-045 resetn low during DATA -> the next cycle shows IDLE, all valids 0, and busy 0.
